motor_time_slice_arbiter: RTL
=============================

// Module: motor_time_slice_arbiter
// PURPOSE
//   Shares one motor power supply between two motor_controller-class H-bridge channels: at most one
//   MOTOR_EN is high at any time. Grants run time round-robin in slices, enforces a dead time
//   after every enable-off and after reset, and changes MOTOR_DIR only while that channel is off.
//   Sits between the debounced switch/button inputs and the motor driver pins in zybo_top.
// PARAMETERS
//   CNT_W       30             width of the shared dead/slice counter
//   DEAD_TIME   30'd124999999  DEAD lasts DEAD_TIME+1 cycles (1 s at 125 MHz)
//   SLICE_TIME  30'd624999999  one grant keeps EN high SLICE_TIME+1 cycles while the other waits (5 s)
// PORTS
//   CLK        in   1  system clock, all logic on rising edge
//   RST        in   1  asynchronous, active-low reset
//   REQ        in   2  run request per channel, synchronous to CLK (synchronised/debounced upstream)
//   DIR_REQ    in   2  requested direction per channel
//   MOTOR_EN   out  2  channel enable, registered, one-hot or zero
//   MOTOR_DIR  out  2  channel direction, registered
//   GRANT      out  1  index of channel currently armed/running (last granted otherwise)
//   BUSY       out  1  high whenever state != IDLE
// BEHAVIOUR
//   - Reset (RST=0, async): state=DEAD, cnt=0, MOTOR_EN=00, MOTOR_DIR=00, GRANT=1 (so ch0 wins first tie).
//     Dead time is therefore always enforced after reset release.
//   - States: DEAD, IDLE, ARM, RUN; g = GRANT.
//   - DEAD: EN=00. cnt==DEAD_TIME -> IDLE; else cnt++.
//   - IDLE: REQ==00 stay. REQ one-hot -> grant that channel. REQ==11 -> grant ~GRANT (round robin).
//     On grant edge: GRANT<=g, MOTOR_DIR[g]<=DIR_REQ[g], state<=ARM. Other channel's DIR untouched.
//   - ARM (exactly 1 cycle, DIR settles before EN): if REQ[g] && DIR_REQ[g]==MOTOR_DIR[g]
//     -> RUN, MOTOR_EN[g]<=1, cnt<=0; else -> IDLE, EN never asserted, no dead time needed.
//   - RUN, evaluated every edge, priority order:
//     1. REQ[g]==0 or DIR_REQ[g]!=MOTOR_DIR[g] -> DEAD, EN<=00, cnt<=0.
//     2. cnt==SLICE_TIME && REQ[~g] -> DEAD, EN<=00, cnt<=0 (slice handover).
//     3. cnt==SLICE_TIME && !REQ[~g] -> cnt<=0, stay RUN, EN stays high (no glitch).
//     4. else cnt++.
//   - Latency: REQ sampled in IDLE -> EN high 2 edges later. Abort in RUN -> EN low next edge.
//     Minimum EN-low gap between any two enables = DEAD_TIME+3 cycles (DEAD+IDLE+ARM).
//   - MOTOR_DIR changes only on the IDLE->ARM edge; never while the same channel's EN is high.
//   - Counter never wraps: compares use ==, cnt reloaded to 0 on every state entry that uses it.
//   - DIR_REQ of the non-granted channel is ignored until its grant.
//   - Reset mid-RUN/ARM: EN=00 immediately without a clock edge; restart in DEAD.
//   - Invariant: MOTOR_EN != 11 in every cycle; BUSY=0 only in IDLE.
// TESTING (DEAD_TIME=4, SLICE_TIME=9)
//   1. REQ=01, DIR_REQ=01 held through reset release -> EN=00 for edges 1-6, MOTOR_DIR[0]=1 after edge 6,
//      EN=01 after edge 7.
//   2. ch0 running DIR=0, toggle DIR_REQ[0] at edge a -> EN=00 after a, DIR[0]=1 after a+6,
//      EN=01 after a+7; DIR[0] stable while EN[0]=1.
//   3. REQ=11 after reset -> ch0 granted first; EN=01 for 10 cycles, 7 low cycles, EN=10 for 10,
//      then ch0 again; EN never 11.
//   4. REQ=01 only, run 35 cycles -> EN[0] continuously high across slice boundaries, BUSY=1.
//   5. RST low mid-RUN between edges -> EN=00, DIR=00 asynchronously; after release 1. repeats.
//   6. 1-cycle REQ=10 pulse in IDLE -> ARM then IDLE, DIR[1] updated, EN stays 00, no DEAD entry.

Source files
------------

// File: rtl/motor_time_slice_arbiter.sv
// Time-slice arbiter sharing one motor supply between two H-bridge channels.
// At most one channel is enabled at a time, with a dead time after every enable-off and after reset.
module motor_time_slice_arbiter #(
  parameter int               CNT_W      = 30,
  parameter logic [CNT_W-1:0] DEAD_TIME  = 30'd124999999,
  parameter logic [CNT_W-1:0] SLICE_TIME = 30'd624999999
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] REQ,
  input  logic [1:0] DIR_REQ,
  output logic [1:0] MOTOR_EN,
  output logic [1:0] MOTOR_DIR,
  output logic       GRANT,
  output logic       BUSY
);

  typedef enum logic [1:0] {S_DEAD, S_IDLE, S_ARM, S_RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             pick;
  logic             keep;
  logic             slice_end;

  // On a tie the channel that did not hold the last grant wins.
  assign pick      = (REQ == 2'b11) ? ~GRANT : REQ[1];
  // The running channel may continue only while it still requests the direction it was armed with.
  assign keep      = REQ[GRANT] && (DIR_REQ[GRANT] == MOTOR_DIR[GRANT]);
  assign slice_end = (cnt == SLICE_TIME);
  assign BUSY      = (state != S_IDLE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_DEAD;
      cnt       <= '0;
      MOTOR_EN  <= 2'b00;
      MOTOR_DIR <= 2'b00;
      GRANT     <= 1'b1;
    end else begin
      case (state)
        S_DEAD: begin
          MOTOR_EN <= 2'b00;
          if (cnt == DEAD_TIME) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (REQ != 2'b00) begin
            GRANT           <= pick;
            MOTOR_DIR[pick] <= DIR_REQ[pick];
            state           <= S_ARM;
          end
        end
        // One cycle with DIR settled before EN rises; a dropped request needs no dead time.
        S_ARM: begin
          if (keep) begin
            state    <= S_RUN;
            MOTOR_EN <= GRANT ? 2'b10 : 2'b01;
            cnt      <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (!keep || (slice_end && REQ[~GRANT])) begin
            state    <= S_DEAD;
            MOTOR_EN <= 2'b00;
            cnt      <= '0;
          end else if (slice_end) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state    <= S_DEAD;
          MOTOR_EN <= 2'b00;
          cnt      <= '0;
        end
      endcase
    end
  end

endmodule
